byte_lane_sched: RTL



---
 rtl/byte_lane_pkg.sv | 38 +++
 rtl/byte_lane_sched_if.sv | 30 +++
 rtl/byte_lane_perm.sv | 32 +++
 rtl/byte_lane_sched.sv | 139 +++++++++++++
 4 files changed

// File: rtl/byte_lane_pkg.sv
// Shared constants, FSM encoding and map validation for the byte-lane scheduler.
package byte_lane_pkg;

    localparam int LANES = 4;
    localparam int LW    = 8;
    localparam int FW    = 4;
    localparam int CW    = 16;
    localparam int MAP_W = LANES * FW;
    localparam int DW    = LANES * LW;

    // Field m is the output lane that receives input lane m.
    localparam logic [MAP_W-1:0] MAP_DEFAULT = 16'h0123;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // A map is usable only when every field names a real lane and no two
    // input lanes target the same output lane (i.e. it is a permutation).
    function automatic logic map_valid(input logic [MAP_W-1:0] map);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (map[FW*i +: FW] >= FW'(LANES)) begin
                ok = 1'b0;
            end
            for (int j = i + 1; j < LANES; j++) begin
                if (map[FW*i +: FW] == map[FW*j +: FW]) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/byte_lane_sched_if.sv
// Config, input and output handshakes of the byte-lane scheduler.
interface byte_lane_sched_if;
    import byte_lane_pkg::*;

    logic              cfg_valid;
    logic [MAP_W-1:0]  cfg_map;
    logic              cfg_ready;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              busy;
    logic [CW-1:0]     xfer_cnt;

    // Producer/consumer/configuration side.
    modport master (
        output cfg_valid, cfg_map, in_valid, in_data, out_ready,
        input  cfg_ready, cfg_err, in_ready, out_valid, out_data, busy, xfer_cnt
    );

    // Scheduler side.
    modport slave (
        input  cfg_valid, cfg_map, in_valid, in_data, out_ready,
        output cfg_ready, cfg_err, in_ready, out_valid, out_data, busy, xfer_cnt
    );

endinterface

// File: rtl/byte_lane_perm.sv
// Combinational lane crossbar: input lane m is written to output lane map[m].
module byte_lane_perm
    import byte_lane_pkg::*;
(
    input  logic [MAP_W-1:0] map,
    input  logic [DW-1:0]    data,
    output logic [DW-1:0]    perm_data
);

    logic [LANES-1:0][DW-1:0] scat_s;

    for (genvar m = 0; m < LANES; m++) begin : g_lane
        logic [DW-1:0] lane_s;

        // Scatter input lane m into its mapped output position.
        always_comb begin
            lane_s = '0;
            lane_s[map[FW*m +: FW]*LW +: LW] = data[LW*m +: LW];
        end

        assign scat_s[m] = lane_s;
    end

    // Merge the scattered lanes; a valid map leaves every lane written once.
    always_comb begin
        perm_data = '0;
        for (int m = 0; m < LANES; m++) begin
            perm_data = perm_data | scat_s[m];
        end
    end

endmodule

// File: rtl/byte_lane_sched.sv
// Byte-lane scheduler: streams words through the crossbar and swaps the lane
// map only after the output register has drained.
module byte_lane_sched
    import byte_lane_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    byte_lane_sched_if.slave  bus
);

    state_t            state_r;
    state_t            state_s;
    logic [MAP_W-1:0]  map_r;
    logic [DW-1:0]     perm_s;
    logic [DW-1:0]     out_data_r;
    logic              out_valid_r;
    logic              cfg_err_r;
    logic [CW-1:0]     xfer_cnt_r;
    logic              in_ready_s;
    logic              accept_s;
    logic              load_s;
    logic              map_ok_s;

    byte_lane_perm u_perm (
        .map       (map_r),
        .data      (bus.in_data),
        .perm_data (perm_s)
    );

    assign load_s   = (state_r == ST_LOAD);
    assign map_ok_s = map_valid(bus.cfg_map);

    // Input acceptance: only in RUN, pending config wins, and the output
    // register must be free or emptying this cycle. Held low during reset.
    always_comb begin
        if (rst_n && (state_r == ST_RUN) && !bus.cfg_valid &&
            (!out_valid_r || bus.out_ready)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = bus.in_valid && in_ready_s;

    // Next-state logic for the RUN/DRAIN/LOAD controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (bus.cfg_valid) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // A withdrawn request abandons the swap without consuming it.
                if (!bus.cfg_valid) begin
                    state_s = ST_RUN;
                end else if (!out_valid_r || bus.out_ready) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_LOAD: begin
                state_s = ST_RUN;
            end
            default: begin
                state_s = ST_RUN;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Output register: load on accept, empty on consumer take, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= perm_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Active lane map: replaced only by a validated map in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_r <= MAP_DEFAULT;
        end else if (load_s && map_ok_s) begin
            map_r <= bus.cfg_map;
        end else begin
            map_r <= map_r;
        end
    end

    // Rejection flag: one-cycle pulse after a LOAD with a bad map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= load_s && !map_ok_s;
        end
    end

    // Accepted-word counter, free-running with natural wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_r <= '0;
        end else if (accept_s) begin
            xfer_cnt_r <= xfer_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            xfer_cnt_r <= xfer_cnt_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.cfg_ready = load_s;
    assign bus.cfg_err   = cfg_err_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.busy      = (state_r != ST_RUN);
    assign bus.xfer_cnt  = xfer_cnt_r;

endmodule
